// File: rtl/ctrl_issue_pkg.sv
// Shared constants and types for the ctrl_issue head-end of the FC datapath.
// The drain depth is the sum of the downstream ctrl delay stages.
package ctrl_issue_pkg;

    localparam int D_MAC  = 4;
    localparam int D_BIAS = 2;
    localparam int D_RELU = 2;

    localparam int DEF_D_DRAIN   = D_MAC + D_BIAS + D_RELU;
    localparam int DEF_DWIDTH_SZ = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

endpackage

// File: rtl/ctrl_issue_cnt.sv
// Nested input/output index counter for ctrl_issue: in_idx is the inner loop,
// out_idx the outer; exposes the wrap and final-beat flags for the current selection.
module ctrl_issue_cnt
    import ctrl_issue_pkg::*;
#(
    parameter int W = DEF_DWIDTH_SZ
) (
    input  logic         clk,
    input  logic         xrst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] inSize_i,
    input  logic [W-1:0] outSize_i,
    output logic [W-1:0] inIdx_o,
    output logic         lastIn_o,
    output logic         lastBeat_o
);

    logic [W-1:0] inIdx_q, inIdx_d;
    logic [W-1:0] outIdx_q, outIdx_d;
    logic         lastIn;
    logic         lastOut;

    assign lastIn  = (inIdx_q == inSize_i - W'(1));
    assign lastOut = (outIdx_q == outSize_i - W'(1));

    always_comb begin
        inIdx_d  = inIdx_q;
        outIdx_d = outIdx_q;
        if (clr_i) begin
            inIdx_d  = '0;
            outIdx_d = '0;
        end else if (en_i) begin
            if (lastIn) begin
                inIdx_d  = '0;
                outIdx_d = lastOut ? '0 : outIdx_q + W'(1);
            end else begin
                inIdx_d = inIdx_q + W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!xrst) begin
            inIdx_q  <= '0;
            outIdx_q <= '0;
        end else begin
            inIdx_q  <= inIdx_d;
            outIdx_q <= outIdx_d;
        end
    end

    assign inIdx_o    = inIdx_q;
    assign lastIn_o   = lastIn;
    assign lastBeat_o = lastIn && lastOut;

endmodule

// File: rtl/ctrl_issue.sv
// Head-end generator of the start/valid/stop ctrl stream for the FC datapath.
// Optional feature macro: CTRL_ISSUE_STALL_EN adds a stall input that freezes beat issue in S_RUN.
module ctrl_issue
    import ctrl_issue_pkg::*;
#(
    parameter int DWIDTH_SZ = DEF_DWIDTH_SZ,
    parameter int D_DRAIN   = DEF_D_DRAIN
) (
    input  logic                 clk,
    input  logic                 xrst,
    input  logic                 req,
    input  logic [DWIDTH_SZ-1:0] in_size,
    input  logic [DWIDTH_SZ-1:0] out_size,
`ifdef CTRL_ISSUE_STALL_EN
    input  logic                 stall,
`endif
    output logic                 out_ctrl_start,
    output logic                 out_ctrl_valid,
    output logic                 out_ctrl_stop,
    output logic [DWIDTH_SZ-1:0] in_addr,
    output logic [DWIDTH_SZ-1:0] w_addr,
    output logic                 busy,
    output logic                 ack
);

    localparam int DCW = (D_DRAIN > 1) ? $clog2(D_DRAIN) : 1;

    state_e               state_q;
    logic [DWIDTH_SZ-1:0] inSize_q, outSize_q;
    logic [DWIDTH_SZ-1:0] wCnt_q;
    logic [DCW-1:0]       drainCnt_q;
    logic                 lastIssued_q;
    logic                 start_q, valid_q, stop_q, busy_q, ack_q;
    logic [DWIDTH_SZ-1:0] inAddr_q, wAddr_q;

    logic                 stallIn;
    logic                 cntClr, cntEn;
    logic [DWIDTH_SZ-1:0] inIdx;
    logic                 lastIn, lastBeat;

`ifdef CTRL_ISSUE_STALL_EN
    assign stallIn = stall;
`else
    assign stallIn = 1'b0;
`endif

    assign cntClr = (state_q == S_IDLE) && req;
    assign cntEn  = (state_q == S_RUN) && !lastIssued_q && !stallIn;

    ctrl_issue_cnt #(
        .W(DWIDTH_SZ)
    ) u_cnt (
        .clk       (clk),
        .xrst      (xrst),
        .clr_i     (cntClr),
        .en_i      (cntEn),
        .inSize_i  (inSize_q),
        .outSize_i (outSize_q),
        .inIdx_o   (inIdx),
        .lastIn_o  (lastIn),
        .lastBeat_o(lastBeat)
    );

    // S_RUN keeps one extra cycle after the last beat so that beat is on the bus before draining.
    always_ff @(posedge clk) begin
        if (!xrst) begin
            state_q      <= S_IDLE;
            inSize_q     <= '0;
            outSize_q    <= '0;
            wCnt_q       <= '0;
            drainCnt_q   <= '0;
            lastIssued_q <= 1'b0;
            start_q      <= 1'b0;
            valid_q      <= 1'b0;
            stop_q       <= 1'b0;
            busy_q       <= 1'b0;
            ack_q        <= 1'b0;
            inAddr_q     <= '0;
            wAddr_q      <= '0;
        end else begin
            start_q <= 1'b0;
            valid_q <= 1'b0;
            stop_q  <= 1'b0;
            ack_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        inSize_q     <= in_size;
                        outSize_q    <= out_size;
                        wCnt_q       <= '0;
                        lastIssued_q <= 1'b0;
                        busy_q       <= 1'b1;
                        if ((in_size == '0) || (out_size == '0)) begin
                            state_q    <= S_DRAIN;
                            drainCnt_q <= DCW'(D_DRAIN - 1);
                        end else begin
                            state_q <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (lastIssued_q) begin
                        state_q    <= S_DRAIN;
                        drainCnt_q <= DCW'(D_DRAIN - 1);
                    end else if (!stallIn) begin
                        valid_q      <= 1'b1;
                        start_q      <= (inIdx == '0);
                        stop_q       <= lastIn;
                        inAddr_q     <= inIdx;
                        wAddr_q      <= wCnt_q;
                        wCnt_q       <= wCnt_q + DWIDTH_SZ'(1);
                        lastIssued_q <= lastBeat;
                    end
                end
                S_DRAIN: begin
                    if (drainCnt_q == '0) begin
                        state_q <= S_DONE;
                        ack_q   <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        drainCnt_q <= drainCnt_q - DCW'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign out_ctrl_start = start_q;
    assign out_ctrl_valid = valid_q;
    assign out_ctrl_stop  = stop_q;
    assign in_addr        = inAddr_q;
    assign w_addr         = wAddr_q;
    assign busy           = busy_q;
    assign ack            = ack_q;

endmodule

// File: tb/tb_ctrl_issue.sv
// Self-checking bench for ctrl_issue: a queue-based beat model plus ack/busy timing predicted per layer.
// Covers CTRL_ISSUE_STALL_EN builds as well as the default one.
module tb_ctrl_issue;
    import ctrl_issue_pkg::*;

    localparam int W = DEF_DWIDTH_SZ;
    localparam int D = DEF_D_DRAIN;

    logic         clk = 1'b0;
    logic         xrst = 1'b0;
    logic         req = 1'b0;
    logic [W-1:0] inSize = '0;
    logic [W-1:0] outSize = '0;
    logic         stall = 1'b0;
    logic         start, valid, stop, busy, ack;
    logic [W-1:0] inAddr, wAddr;

    ctrl_issue dut (
        .clk           (clk),
        .xrst          (xrst),
        .req           (req),
        .in_size       (inSize),
        .out_size      (outSize),
`ifdef CTRL_ISSUE_STALL_EN
        .stall         (stall),
`endif
        .out_ctrl_start(start),
        .out_ctrl_valid(valid),
        .out_ctrl_stop (stop),
        .in_addr       (inAddr),
        .w_addr        (wAddr),
        .busy          (busy),
        .ack           (ack)
    );

    always #5 clk = ~clk;

    int edgeCnt = 0;
    always @(posedge clk) edgeCnt++;

    typedef struct {
        bit start;
        bit stop;
        int inAddr;
        int wAddr;
    } beat_t;

    beat_t expQ[$];
    int    obsW[$];
    bit    obsSS[$];
    int    errors = 0;
    int    checks = 0;
    bit    monitorOn = 1'b0;
    bit    active = 1'b0;
    int    acceptEdge = 0;
    int    ackEdge = 0;
    int    ackSeenEdge = -1;
    int    beatsSeen = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, edgeCnt);
        end
    endtask

    // Every cycle: busy/ack against the predicted window, each valid beat against the model queue.
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            if (monitorOn) begin
                checkOutput("busy", busy, active && edgeCnt >= acceptEdge && edgeCnt < ackEdge);
                checkOutput("ack", ack, active && edgeCnt == ackEdge);
                if (ack === 1'b1) ackSeenEdge = edgeCnt;
                if (valid === 1'b1) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected beat", 1, 0);
                    end else begin
                        b = expQ.pop_front();
                        checkOutput("start", start, b.start);
                        checkOutput("stop", stop, b.stop);
                        checkOutput("in_addr", inAddr, b.inAddr);
                        checkOutput("w_addr", wAddr, b.wAddr);
                        beatsSeen++;
                        obsW.push_back(int'(wAddr));
                        obsSS.push_back(start && stop);
                    end
                end else begin
                    checkOutput("start without valid", start, 0);
                    checkOutput("stop without valid", stop, 0);
                end
            end
        end
    end

    // Issue one layer request and predict its beats and ack edge from the size rules.
    task automatic startLayer(input int nIn, input int nOut, input int stallCycles);
        int n;
        beat_t b;
        @(negedge clk);
        #1;
        inSize = W'(nIn);
        outSize = W'(nOut);
        req = 1'b1;
        n = nIn * nOut;
        acceptEdge = edgeCnt + 1;
        ackEdge = acceptEdge + ((n > 0) ? (n + 1 + D) : D) + stallCycles;
        expQ.delete();
        obsW.delete();
        obsSS.delete();
        beatsSeen = 0;
        ackSeenEdge = -1;
        for (int o = 0; o < nOut; o++) begin
            for (int i = 0; i < nIn; i++) begin
                b.start = (i == 0);
                b.stop = (i == nIn - 1);
                b.inAddr = i;
                b.wAddr = (o * nIn + i) % 65536;
                expQ.push_back(b);
            end
        end
        active = 1'b1;
        @(negedge clk);
        #1;
        req = 1'b0;
        inSize = W'($urandom_range(1, 9));
        outSize = W'($urandom_range(1, 9));
    endtask

    task automatic applyStimulus(input int nIn, input int nOut, input int stallCycles,
                                 input bit midReq, input bit reqAtAck);
        startLayer(nIn, nOut, stallCycles);
        if (stallCycles > 0) begin
            while (edgeCnt < acceptEdge + 2) @(negedge clk);
            #1;
            stall = 1'b1;
            repeat (stallCycles) @(negedge clk);
            #1;
            stall = 1'b0;
        end
        if (midReq) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            #1;
            req = 1'b1;
            @(negedge clk);
            #1;
            req = 1'b0;
        end
        while (edgeCnt < ackEdge) @(negedge clk);
        if (reqAtAck) begin
            #1;
            req = 1'b1;
            @(negedge clk);
            #1;
            req = 1'b0;
        end else begin
            @(negedge clk);
        end
        checkOutput("beat count", beatsSeen, nIn * nOut);
        checkOutput("model queue drained", expQ.size(), 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("reset valid", valid, 0);
        checkOutput("reset start", start, 0);
        checkOutput("reset stop", stop, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset ack", ack, 0);
        checkOutput("reset in_addr", inAddr, 0);
        checkOutput("reset w_addr", wAddr, 0);
        #1;
        xrst = 1'b1;
        monitorOn = 1'b1;

        $display("[TB] layer 4x2");
        applyStimulus(4, 2, 0, 1'b0, 1'b0);
        checkOutput("t1 ack offset", ackSeenEdge - acceptEdge, 8 + D + 1);
        checkOutput("t1 w_addr beat 7", obsW[7], 7);
        checkOutput("t1 w_addr beat 4", obsW[4], 4);

        $display("[TB] layer 1x3");
        applyStimulus(1, 3, 0, 1'b0, 1'b0);
        checkOutput("t2 beats", obsW.size(), 3);
        for (int k = 0; k < 3; k++) begin
            checkOutput("t2 start=stop", obsSS[k], 1);
            checkOutput("t2 w_addr", obsW[k], k);
        end

        $display("[TB] layer 0x5");
        applyStimulus(0, 5, 0, 1'b0, 1'b1);
        checkOutput("t3 ack offset", ackSeenEdge - acceptEdge, D);

        $display("[TB] req while busy");
        applyStimulus(3, 3, 0, 1'b1, 1'b0);

        $display("[TB] reset mid-run");
        startLayer(4, 2, 0);
        for (int g = 0; g < 40 && beatsSeen < 4; g++) begin
            @(negedge clk);
            #1;
        end
        checkOutput("t5 beats before reset", beatsSeen, 4);
        xrst = 1'b0;
        active = 1'b0;
        expQ.delete();
        @(negedge clk);
        checkOutput("t5 valid", valid, 0);
        checkOutput("t5 start", start, 0);
        checkOutput("t5 busy", busy, 0);
        checkOutput("t5 in_addr", inAddr, 0);
        checkOutput("t5 w_addr", wAddr, 0);
        #1;
        xrst = 1'b1;
        applyStimulus(4, 2, 0, 1'b0, 1'b0);
        checkOutput("t5 restart w_addr beat 0", obsW[0], 0);

`ifdef CTRL_ISSUE_STALL_EN
        $display("[TB] stall 3 cycles at beat 2");
        applyStimulus(4, 2, 3, 1'b0, 1'b0);
        checkOutput("t6 ack offset", ackSeenEdge - acceptEdge, 8 + D + 1 + 3);
        checkOutput("t6 w_addr beat 2", obsW[2], 2);
`endif

        $display("[TB] random layers");
        for (int t = 0; t < 12; t++) begin
            applyStimulus($urandom_range(0, 5), $urandom_range(0, 4), 0,
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
